// File: rtl/top_formal_pkg.sv
// Shared types and constants for the on-fabric formal stimulus generator:
// FSM state enum, Galois LFSR tap masks and the zero-seed guard.
package top_formal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    RUN,
    DRAIN,
    DONE
  } formal_state_t;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;

  // Right-shift Galois tap mask for a given width; unknown widths fall back to the 16-bit mask.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return 64'(LFSR_TAPS_8);
      default: return 64'(LFSR_TAPS_16);
    endcase
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [63:0] nonzero_seed(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/top_formal_stimulus_gen_if.sv
// Handshake, stimulus and response bundle between the test controller,
// the stimulus generator and the DUT/reference pins.
interface top_formal_stimulus_gen_if #(
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 1,
  parameter int CNT_W   = 16
);

  logic               start_i;
  logic [CNT_W-1:0]   run_len_i;
  logic [NUM_IN-1:0]  stim_o;
  logic               stim_valid_o;
  logic               busy_o;
  logic               done_o;
  logic [NUM_OUT-1:0] dut_out_i;
  logic [NUM_OUT-1:0] ref_out_i;
  logic               mismatch_o;
  logic [CNT_W-1:0]   err_cnt_o;

  // Controller / DUT-harness side
  modport master (
    output start_i, run_len_i, dut_out_i, ref_out_i,
    input  stim_o, stim_valid_o, busy_o, done_o, mismatch_o, err_cnt_o
  );

  // Stimulus generator side
  modport slave (
    input  start_i, run_len_i, dut_out_i, ref_out_i,
    output stim_o, stim_valid_o, busy_o, done_o, mismatch_o, err_cnt_o
  );

endinterface

// File: rtl/formal_lfsr.sv
// Right-shift Galois LFSR with synchronous reset/load to a fixed seed and an
// advance enable; load has priority over advance.
module formal_lfsr
  import top_formal_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = LFSR_TAPS_16,
  parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] state
);

  logic [W-1:0] state_reg;
  logic [W-1:0] state_next;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = SEED;
    end else if (advance) begin
      state_next = (state_reg >> 1) ^ (state_reg[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/top_formal_stimulus_gen.sv
// Bounded pseudo-random stimulus generator with start/done handshake and an
// optional response comparator/error counter enabled by SELF_CHECK_EN.
module top_formal_stimulus_gen
  import top_formal_pkg::*;
#(
  parameter int                NUM_IN  = 2,
  parameter int                NUM_OUT = 1,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                CNT_W   = 16
) (
  input logic                      clk,
  input logic                      reset,
  top_formal_stimulus_gen_if.slave bus
);

  localparam logic [LFSR_W-1:0] SEED_EFF   = LFSR_W'(nonzero_seed(64'(SEED)));
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(lfsr_taps(LFSR_W));

  formal_state_t     state_reg;
  formal_state_t     state_next;
  logic [CNT_W-1:0]  rem_reg;
  logic [CNT_W-1:0]  rem_next;
  logic              start_ok;
  logic              lfsr_load;
  logic              lfsr_advance;
  logic [LFSR_W-1:0] lfsr_state;
  logic              stim_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  formal_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_advance),
    .state   (lfsr_state)
  );

  // rem_reg holds the number of RUN cycles still to go, including the current one.
  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    start_ok     = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start_i) begin
          if (bus.run_len_i == '0) begin
            state_next = DONE;
          end else begin
            state_next = APPLY;
            rem_next   = bus.run_len_i - CNT_W'(1);
            start_ok   = 1'b1;
            lfsr_load  = 1'b1;
          end
        end
      end
      APPLY: begin
        if (rem_reg == '0) begin
          state_next = DRAIN;
        end else begin
          state_next   = RUN;
          lfsr_advance = 1'b1;
        end
      end
      RUN: begin
        if (rem_reg == CNT_W'(1)) begin
          state_next = DRAIN;
        end else begin
          rem_next     = rem_reg - CNT_W'(1);
          lfsr_advance = 1'b1;
        end
      end
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rem_reg        <= '0;
      stim_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      stim_valid_reg <= (state_next == APPLY) || (state_next == RUN);
      busy_reg       <= (state_next == APPLY) || (state_next == RUN) || (state_next == DRAIN);
      done_reg       <= (state_next == DONE);
    end
  end

  assign bus.stim_o       = lfsr_state[NUM_IN-1:0];
  assign bus.stim_valid_o = stim_valid_reg;
  assign bus.busy_o       = busy_reg;
  assign bus.done_o       = done_reg;

`ifdef SELF_CHECK_EN
  logic [NUM_OUT-1:0] bit_diff;
  logic               compare_en;
  logic               mismatch_reg;
  logic [CNT_W-1:0]   err_cnt_reg;
  logic               unused_lfsr;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_diff
    assign bit_diff[gi] = bus.dut_out_i[gi] ^ bus.ref_out_i[gi];
  end

  // Responses lag their vector by one cycle, so RUN and DRAIN are the compare cycles.
  assign compare_en  = (state_reg == RUN) || (state_reg == DRAIN);
  assign unused_lfsr = ^lfsr_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      mismatch_reg <= compare_en && (|bit_diff);
      if (start_ok) begin
        err_cnt_reg <= '0;
      end else if (compare_en && (|bit_diff) && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.mismatch_o = mismatch_reg;
  assign bus.err_cnt_o  = err_cnt_reg;
`else
  logic unused_inputs;

  assign unused_inputs  = ^{bus.dut_out_i, bus.ref_out_i, start_ok, lfsr_state};
  assign bus.mismatch_o = 1'b0;
  assign bus.err_cnt_o  = '0;
`endif

endmodule

// File: doc/top_formal_stimulus_gen.md
# top_formal_stimulus_gen

- Synthesizable stimulus transmitter for on-fabric formal/random verification of the mapped `top` design.
- Produces a bounded stream of pseudo-random input vectors (`a`, `b`, …) from an LFSR under a start/done handshake. Drives both the FPGA-mapped DUT and the golden reference.
- Optionally compares their responses cycle by cycle and counts mismatches.
- Sits between the test controller (or scan/config logic) and the DUT/reference input pins.

## Interface
Parameters:
- `NUM_IN`, 2: stimulus width; bit 0 = `a`, bit 1 = `b`.
- `NUM_OUT`, 1: response width compared.
- `LFSR_W`, 16: LFSR width; must be ≥ `NUM_IN`.
- `SEED`, 16'hACE1: LFSR reset/restart value; a value of 0 is replaced by 1.
- `CNT_W`, 16: width of the run-length and error counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin a run; sampled only in IDLE or DONE.
- `run_len_i`  in  CNT_W  number of vectors N; latched on accepted start.
- `stim_o`  out  NUM_IN  current vector = `lfsr[NUM_IN-1:0]`.
- `stim_valid_o`  out  1  high while a new vector is being applied.
- `busy_o`  out  1  high in APPLY, RUN, DRAIN.
- `done_o`  out  1  high in DONE; held until next start or reset.
- `dut_out_i`  in  NUM_OUT  FPGA-mapped response.
- `ref_out_i`  in  NUM_OUT  reference response.
- `mismatch_o`  out  1  registered; high one cycle after a failing compare.
- `err_cnt_o`  out  CNT_W  saturating mismatch count.

## Operation
FSM states are IDLE, APPLY, RUN, DRAIN, DONE.

- **IDLE**
  - `start_i`=1 with N=0 → DONE.
  - `start_i`=1 with N≥1 → APPLY. Latch N, reseed LFSR to SEED, clear `err_cnt_o`.
- **APPLY** (1 cycle)
  - Vector v0 = seed bits on `stim_o`; no compare.
  - Goes to RUN if N≥2, else to DRAIN.
- **RUN** (N−1 cycles)
  - Each cycle the LFSR advances, so `stim_o` = v1 … v(N−1).
  - Each cycle compares responses r0 … r(N−2).
  - Exits to DRAIN after N−1 cycles.
- **DRAIN** (1 cycle)
  - Compares r(N−1); `stim_o` holds v(N−1); `stim_valid_o`=0.
  - Goes to DONE.
- **DONE**
  - `stim_o` holds the last vector.
  - `start_i`=1 restarts exactly as from IDLE (new seed, counter cleared).

General rules:
- LFSR is Galois, right-shift: next = (l>>1) ^ (l[0] ? TAPS : 0), with TAPS = 16'hB400 for `LFSR_W`=16.
- `start_i` is ignored while `busy_o`=1.
- Compare: mismatch when `dut_out_i` != `ref_out_i` on any bit. The DUT and reference are combinational from `stim_o`, so the response to a vector is sampled the cycle after that vector is applied.
- `err_cnt_o` increments by 1 per mismatching cycle and saturates at 2^CNT_W−1.
- Mid-run reset behaves exactly like power-on reset; no partial results are retained.

## Timing
Reset values:
- state = IDLE, LFSR = SEED, `stim_o` = SEED[NUM_IN-1:0].
- `stim_valid_o`, `busy_o`, `done_o`, `mismatch_o` = 0; `err_cnt_o` = 0.

Cycle-level behaviour:
- Start accepted at cycle t → APPLY at t+1 → DONE at t+N+2.
- `done_o` rises at t+N+2. For N=0, `done_o` rises at t+1.
- `mismatch_o` and the `err_cnt_o` update appear one cycle after the compare cycle. The final update is therefore visible in the first DONE cycle.
- All outputs are registered.

## Configuration
- `SELF_CHECK_EN` defined: compare logic, `mismatch_o` and `err_cnt_o` are active as described above.
- `SELF_CHECK_EN` undefined:
  - No compare logic is built.
  - `mismatch_o`=0 and `err_cnt_o`=0 constantly.
  - `dut_out_i`/`ref_out_i` stay in the port list but are unused.
  - Stimulus generation and FSM timing are unchanged.

## Structure
- Package `top_formal_pkg` holds:
  - the state enum `formal_state_t` (IDLE/APPLY/RUN/DRAIN/DONE);
  - `LFSR_TAPS_16` = 16'hB400;
  - the zero-seed guard function.
- Sub-module `formal_lfsr` has ports `clk`, `reset`, load, advance, and state output.
- FSM, run counter and error counter live in the top module.

## Test plan
- Reset, then start with N=4 and SEED=16'hACE1 → `stim_o` sequence {a,b} = (1,0), (0,0), (0,0), (0,0), from LFSR values ACE1, E270, 7138, 389C. `done_o` rises 6 cycles after start; `err_cnt_o`=0.
- N=4 with `ref_out_i` forced to the inverse of `dut_out_i` during the RUN/DRAIN compares → `err_cnt_o`=4; `mismatch_o` high for 4 consecutive cycles.
- N=0 → `done_o` one cycle after start; `stim_valid_o` never asserts.
- Start pulsed again in RUN → ignored. Then start in DONE → LFSR restarts at ACE1 and the counter clears.
- Reset asserted in the 2nd RUN cycle → next cycle IDLE, all outputs at reset values. A subsequent run of N=4 repeats the first scenario exactly.
- Built without `SELF_CHECK_EN` and forced mismatches → `err_cnt_o`=0 and `mismatch_o`=0; stimulus identical to the first scenario.
